// File: rtl/stack_engine_if.sv
// Op-side and memory-side signal bundle for stack_engine.
// slave = the engine, master = control unit / memory arbiter side.
interface stack_engine_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 7
);
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] sp;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              fault_ovf;
  logic              fault_unf;
  logic              fault_clr;

  modport slave (
    input  op_valid, op, wdata, mem_ack, mem_rdata, fault_clr,
    output op_ready, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata,
           sp, count, empty, full, fault_ovf, fault_unf
  );

  modport master (
    output op_valid, op, wdata, mem_ack, mem_rdata, fault_clr,
    input  op_ready, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata,
           sp, count, empty, full, fault_ovf, fault_unf
  );
endinterface

// File: rtl/stack_engine.sv
// Full-descending hardware stack controller: owns SP and entry count and
// sequences push/pop/peek/clear against a req/ack data-memory port.
module stack_engine #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 16'h0400,
  parameter int                STACK_DEPTH = 64,
  parameter int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  stack_engine_if.slave bus
);

  if (STACK_DEPTH < 1 || $unsigned(STACK_DEPTH) > 32'(STACK_TOP)) begin : g_param_check
    $error("stack_engine: STACK_DEPTH must be in 1..STACK_TOP");
  end

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_ovf_q, fault_ovf_d;
  logic              fault_unf_q, fault_unf_d;
  logic              pop_q, pop_d;
  logic              set_ovf, set_unf;
  logic              is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(STACK_DEPTH));

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    count_d     = count_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    pop_d       = pop_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op)
            OP_PUSH: begin
              if (is_full) begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                set_ovf = 1'b1;
              end else begin
                state_d     = WAIT_WR;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_q - ADDR_W'(1);
                mem_wdata_d = bus.wdata;
              end
            end
            OP_POP, OP_PEEK: begin
              if (is_empty) begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                set_unf = 1'b1;
              end else begin
                state_d    = WAIT_RD;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = sp_q;
                pop_d      = (bus.op == OP_POP);
              end
            end
            default: begin
              sp_d    = STACK_TOP;
              count_d = '0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      WAIT_WR: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          sp_d      = sp_q - ADDR_W'(1);
          count_d   = count_q + CNT_W'(1);
          done_d    = 1'b1;
        end
      end
      WAIT_RD: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
          done_d    = 1'b1;
          if (pop_q) begin
            sp_d    = sp_q + ADDR_W'(1);
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new fault in this cycle blocks the clear so it cannot be lost.
    fault_ovf_d = fault_ovf_q;
    fault_unf_d = fault_unf_q;
    if (set_ovf || set_unf) begin
      fault_ovf_d = fault_ovf_q | set_ovf;
      fault_unf_d = fault_unf_q | set_unf;
    end else if (bus.fault_clr) begin
      fault_ovf_d = 1'b0;
      fault_unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sp_q        <= STACK_TOP;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      fault_ovf_q <= 1'b0;
      fault_unf_q <= 1'b0;
      pop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      fault_ovf_q <= fault_ovf_d;
      fault_unf_q <= fault_unf_d;
      pop_q       <= pop_d;
    end
  end

  assign bus.op_ready  = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sp        = sp_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.fault_ovf = fault_ovf_q;
  assign bus.fault_unf = fault_unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine (STACK_TOP=0x0400, depth 4) with a
// req/ack memory responder of programmable wait.
module tb_stack_engine;

  typedef struct {
    logic        e_err;
    logic        e_chk;
    logic [15:0] e_rdata;
    logic [15:0] e_sp;
    logic [2:0]  e_cnt;
    int          e_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ack_delay = 0;
  int   wcnt = 0;
  bit   mem_auto = 1'b1;
  logic [15:0] mem [0:65535];
  exp_t sb [$];

  stack_engine_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(3)) ifc ();

  stack_engine #(
    .DATA_W(16), .ADDR_W(16), .STACK_TOP(16'h0400), .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay extra req cycles.
  always @(negedge clk) begin
    if (mem_auto) begin
      if (ifc.mem_req && !ifc.mem_ack) begin
        if (wcnt >= ack_delay) begin
          if (ifc.mem_we) mem[ifc.mem_addr] = ifc.mem_wdata;
          ifc.mem_rdata = mem[ifc.mem_addr];
          ifc.mem_ack = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        ifc.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.err && !ifc.done) chk("err_without_done", 32'(ifc.err), 32'h0);
    if (ifc.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(ifc.done), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("done_err", 32'(ifc.err), 32'(e.e_err));
        if (e.e_chk) chk("done_rdata", 32'(ifc.rdata), 32'(e.e_rdata));
        chk("done_sp", 32'(ifc.sp), 32'(e.e_sp));
        chk("done_count", 32'(ifc.count), 32'(e.e_cnt));
        chk("done_cycle", 32'(cyc), 32'(e.e_cyc));
        chk("done_op_ready", 32'(ifc.op_ready), 32'h1);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] d, input logic clr,
                       input bit exp_en, input logic e_err, input logic e_chk,
                       input logic [15:0] e_rd, input logic [15:0] e_sp,
                       input logic [2:0] e_cnt, input int lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!ifc.op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.op_ready) begin
      chk("op_ready_timeout", 32'(ifc.op_ready), 32'h1);
      return;
    end
    ifc.op_valid = 1'b1;
    ifc.op = o;
    ifc.wdata = d;
    ifc.fault_clr = clr;
    @(posedge clk);
    #1;
    if (exp_en) begin
      e.e_err = e_err; e.e_chk = e_chk; e.e_rdata = e_rd;
      e.e_sp = e_sp; e.e_cnt = e_cnt; e.e_cyc = cyc + lat;
      sb.push_back(e);
    end
    ifc.op_valid = 1'b0;
    ifc.fault_clr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (sb.size() == 0) break;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.op_valid = 1'b0; ifc.op = 2'b00; ifc.wdata = '0;
    ifc.mem_ack = 1'b0; ifc.mem_rdata = '0; ifc.fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sp", 32'(ifc.sp), 32'h0400);
    chk("rst_count", 32'(ifc.count), 32'h0);
    chk("rst_empty", 32'(ifc.empty), 32'h1);
    chk("rst_full", 32'(ifc.full), 32'h0);
    chk("rst_mem_req", 32'(ifc.mem_req), 32'h0);
    chk("rst_op_ready", 32'(ifc.op_ready), 32'h1);
    chk("rst_done", 32'(ifc.done), 32'h0);
    chk("rst_rdata", 32'(ifc.rdata), 32'h0);
    chk("rst_faults", {30'h0, ifc.fault_ovf, ifc.fault_unf}, 32'h0);
    rst = 1'b1;

    // Zero-wait pushes
    ack_delay = 0;
    issue(2'b00, 16'h00A1, 1'b0, 1, 0, 0, 16'h0, 16'h03FF, 3'd1, 1);
    @(negedge clk);
    chk("push1_req", {29'h0, ifc.mem_req, ifc.mem_we, ifc.op_ready}, 32'h6);
    chk("push1_addr", 32'(ifc.mem_addr), 32'h03FF);
    chk("push1_wdata", 32'(ifc.mem_wdata), 32'h00A1);
    wait_done();
    issue(2'b00, 16'h00B2, 1'b0, 1, 0, 0, 16'h0, 16'h03FE, 3'd2, 1);
    @(negedge clk);
    chk("push2_addr", 32'(ifc.mem_addr), 32'h03FE);
    wait_done();
    chk("mem_3ff", 32'(mem[16'h03FF]), 32'h00A1);
    chk("mem_3fe", 32'(mem[16'h03FE]), 32'h00B2);

    // Delayed reads: peek then pop
    ack_delay = 3;
    issue(2'b10, 16'h0, 1'b0, 1, 0, 1, 16'h00B2, 16'h03FE, 3'd2, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("peek_hold", {15'h0, ifc.mem_req, ifc.mem_addr}, 32'h0001_03FE);
      chk("peek_busy", 32'(ifc.op_ready), 32'h0);
    end
    wait_done();
    issue(2'b01, 16'h0, 1'b0, 1, 0, 1, 16'h00B2, 16'h03FF, 3'd1, 4);
    wait_done();

    // Fill to depth then overflow
    ack_delay = 0;
    issue(2'b00, 16'h00C3, 1'b0, 1, 0, 0, 16'h0, 16'h03FE, 3'd2, 1);
    issue(2'b00, 16'h00D4, 1'b0, 1, 0, 0, 16'h0, 16'h03FD, 3'd3, 1);
    issue(2'b00, 16'h00E5, 1'b0, 1, 0, 0, 16'h0, 16'h03FC, 3'd4, 1);
    wait_done();
    chk("full_flag", 32'(ifc.full), 32'h1);
    issue(2'b00, 16'h00FF, 1'b0, 1, 1, 0, 16'h0, 16'h03FC, 3'd4, 0);
    chk("ovf_no_req", 32'(ifc.mem_req), 32'h0);
    wait_done();
    chk("fault_ovf", 32'(ifc.fault_ovf), 32'h1);
    issue(2'b00, 16'h00FF, 1'b1, 1, 1, 0, 16'h0, 16'h03FC, 3'd4, 0);
    wait_done();
    chk("fault_ovf_beats_clr", 32'(ifc.fault_ovf), 32'h1);
    chk("mem_3fc", 32'(mem[16'h03FC]), 32'h00E5);

    // Clear, underflow, fault clear
    issue(2'b11, 16'h0, 1'b0, 1, 0, 0, 16'h0, 16'h0400, 3'd0, 0);
    wait_done();
    chk("clear_empty", 32'(ifc.empty), 32'h1);
    chk("clear_keeps_ovf", 32'(ifc.fault_ovf), 32'h1);
    issue(2'b01, 16'h0, 1'b0, 1, 1, 0, 16'h0, 16'h0400, 3'd0, 0);
    wait_done();
    chk("fault_unf", 32'(ifc.fault_unf), 32'h1);
    @(negedge clk); ifc.fault_clr = 1'b1;
    @(negedge clk); ifc.fault_clr = 1'b0;
    chk("faults_cleared", {30'h0, ifc.fault_ovf, ifc.fault_unf}, 32'h0);

    // Reset abandons a pending memory access
    issue(2'b00, 16'h0066, 1'b0, 1, 0, 0, 16'h0, 16'h03FF, 3'd1, 1);
    wait_done();
    mem_auto = 1'b0;
    ifc.mem_ack = 1'b0;
    issue(2'b00, 16'h0077, 1'b0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0);
    @(negedge clk);
    chk("pend_req", 32'(ifc.mem_req), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_req", 32'(ifc.mem_req), 32'h0);
    chk("rstwait_sp", 32'(ifc.sp), 32'h0400);
    chk("rstwait_count", 32'(ifc.count), 32'h0);
    rst = 1'b1;
    ifc.mem_ack = 1'b1;
    ifc.mem_rdata = 16'h1234;
    @(negedge clk);
    ifc.mem_ack = 1'b0;
    chk("late_ack_done", 32'(ifc.done), 32'h0);
    chk("late_ack_sp", 32'(ifc.sp), 32'h0400);
    chk("late_ack_count", 32'(ifc.count), 32'h0);
    chk("late_ack_rdata", 32'(ifc.rdata), 32'h0);
    repeat (2) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
Parametrised hardware stack controller that replaces the CPU's fixed 16-bit SP register and its combinational push/pop address mux. It owns the stack pointer and entry count, and sequences push, pop, peek and clear operations against a data-memory port with a req/ack handshake, so memory may take multiple cycles. It adds full/empty status and sticky overflow/underflow faults, which the current SP logic does not have. It sits between the control unit (op side) and the data-memory arbiter (mem side).

Parameters:
DATA_W, 16, width of stack entries and memory data
ADDR_W, 16, width of memory address and SP
STACK_TOP, 16'h0400, SP value when the stack is empty (full-descending stack)
STACK_DEPTH, 64, maximum entries; must be ≥1 and ≤ STACK_TOP (elaboration-time check)
CNT_W, $clog2(STACK_DEPTH+1), width of count (derived)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
op_valid  in  1  operation request
op_ready  out  1  engine can accept an op; high only in IDLE
op  in  2  00 push, 01 pop, 10 peek, 11 clear
wdata  in  DATA_W  push data, sampled on acceptance
done  out  1  one-cycle pulse on completion of every accepted op
err  out  1  valid with done; 1 = op rejected (overflow or underflow)
rdata  out  DATA_W  pop/peek result, valid when done=1 and err=0; holds its value otherwise
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write (push), 0 = read (pop/peek)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion; ignored while mem_req=0
mem_rdata  in  DATA_W  read data, sampled in the ack cycle
sp  out  ADDR_W  current stack pointer
count  out  CNT_W  current number of entries
empty  out  1  count==0
full  out  1  count==STACK_DEPTH
fault_ovf  out  1  sticky: push attempted while full
fault_unf  out  1  sticky: pop/peek attempted while empty
fault_clr  in  1  clears both sticky faults

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, sp=STACK_TOP, count=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, rdata=0, faults=0. A reset during a memory wait abandons the access; mem_req is 0 in the following cycle.
- Stack discipline: push writes to sp-1, then sp←sp-1 and count+1. Pop reads at sp, then sp←sp+1 and count-1. Peek reads at sp and changes nothing. Address arithmetic is modulo 2^ADDR_W; the parameter check guarantees no wrap in legal use.
- An op is accepted at an edge where op_valid=1 and op_ready=1. op and wdata are captured at that edge.
- FSM states: IDLE, WAIT_WR, WAIT_RD.
  - IDLE, accept push, not full → WAIT_WR: mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=wdata.
  - IDLE, accept pop or peek, not empty → WAIT_RD: mem_req=1, mem_we=0, mem_addr=sp.
  - IDLE, accept push while full → stay in IDLE: no memory access, done=1 and err=1 next cycle, fault_ovf set, sp and count unchanged.
  - IDLE, accept pop or peek while empty → same as above, but fault_unf is set.
  - IDLE, accept clear → sp=STACK_TOP and count=0 at the next edge, done=1, err=0. Faults are unaffected; no memory access.
  - WAIT_*: mem_req, mem_we, mem_addr and mem_wdata are held stable. At the edge where mem_ack=1: mem_req←0, sp and count update (pop/push), rdata←mem_rdata (read), done←1, state←IDLE.
- Timing: op_ready is low throughout WAIT_*.
  - Memory op latency: accepted at edge N → mem_req high from cycle N+1 → ack sampled at edge M → done high in cycle M+1, together with op_ready.
  - Zero-wait memory (ack in the first req cycle) gives done two cycles after acceptance.
  - Rejected ops and clear complete in one cycle, so back-to-back acceptance every cycle is allowed.
- done is a single-cycle pulse. err is 0 whenever done is 0.
- Faults: set conditions take priority over fault_clr in the same cycle. fault_clr with no set condition clears both faults.
- empty and full are combinational from count. sp and count are registered outputs.

Test Plan:
- Reset with STACK_TOP=16'h0400, DEPTH=4 → sp=0x0400, count=0, empty=1, full=0, mem_req=0, op_ready=1.
- Push 0xA1, 0xB2 with ack in the first req cycle → writes at 0x03FF then 0x03FE; sp=0x03FE; count=2; done two cycles after each accept.
- Peek then pop with ack delayed 3 cycles → mem_req/addr 0x03FE stable for 3 cycles. Peek returns rdata=0xB2 with sp unchanged; pop returns 0xB2 with sp=0x03FF, count=1.
- Fill to 4 entries, then push 0xFF → no mem_req; done=1, err=1 next cycle; fault_ovf=1; sp=0x03FC unchanged. Assert fault_clr while a second overflowing push is accepted → fault_ovf stays 1.
- Pop on empty → err=1, fault_unf=1. Then fault_clr alone → both faults 0.
- Accept a push, drop rst to 0 while mem_req is waiting → mem_req=0 next cycle, sp=0x0400, count=0; a late mem_ack is ignored.
